ddr_frame_rw_ctrl: RTL and testbench
====================================

Name: ddr_frame_rw_ctrl

Overview:
- User-side initiator for the DDR burst interface. Moves pixel data into DDR and back out through two FIFOs.
- Issues write bursts when the ingress FIFO holds at least one burst of data. Issues read bursts when the egress FIFO has room for one burst.
- Keeps a frame-relative address pointer per direction, with wrap-around.
- Sits between the video-side FIFOs and the DDR burst controller, which drives the MIG app interface.

Parameters:
- ADDR_WIDTH, 28, DDR app address width
- DATA_WIDTH, 128, beat width
- BURST_LEN, 64, beats per burst (1..1023)
- ADDR_STEP, 8, app-address increment per beat
- FRAME_BEATS, 259200, beats per frame; must be a multiple of BURST_LEN
- WR_BASE, 0, frame base address for writes
- RD_BASE, 0, frame base address for reads
- FIFO_CNT_W, 11, width of FIFO fill counts
- RD_FIFO_DEPTH, 1024, egress FIFO depth in beats

Ports:
- ui_clk  in  1  clock
- ui_clk_sync_rst  in  1  synchronous, active-high reset
- init_calib_complete  in  1  DDR calibrated
- frame_sync  in  1  one-cycle pulse: restart both pointers at base
- rd_enable  in  1  read path enabled
- wr_fifo_cnt  in  FIFO_CNT_W  ingress FIFO fill level
- wr_fifo_dout  in  DATA_WIDTH  ingress FIFO data (first-word-fall-through)
- wr_fifo_rd_en  out  1  ingress FIFO pop
- rd_fifo_cnt  in  FIFO_CNT_W  egress FIFO fill level
- rd_fifo_wr_en  out  1  egress FIFO push
- rd_fifo_din  out  DATA_WIDTH  egress FIFO data
- wr_burst_req  out  1  write burst request pulse
- wr_burst_len  out  10  = BURST_LEN
- wr_burst_addr  out  ADDR_WIDTH  write burst start address
- wr_burst_data_req  in  1  controller takes wr_burst_data this cycle
- wr_burst_data  out  DATA_WIDTH  write beat
- wr_burst_finish  in  1  write burst done
- rd_burst_req  out  1  read burst request pulse
- rd_burst_len  out  10  = BURST_LEN
- rd_burst_addr  out  ADDR_WIDTH  read burst start address
- rd_burst_data_valid  in  1  read beat valid
- rd_burst_data  in  DATA_WIDTH  read beat
- rd_burst_finish  in  1  read burst done
- wr_frame_done  out  1  one-cycle pulse: last write burst of frame finished
- rd_frame_done  out  1  one-cycle pulse: last read burst of frame finished

Behaviour:
- Clock and reset: single clock ui_clk. Reset ui_clk_sync_rst is synchronous and active-high.
- Reset values: all outputs 0 except wr_burst_len/rd_burst_len, which are constant BURST_LEN. Addresses reset to WR_BASE/RD_BASE. State resets to IDLE.
- Reset mid-burst: abandon the burst. No finish wait, pointers return to base.
- State machine: IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT.
- IDLE: act only when init_calib_complete=1.
  - wr_ok = wr_fifo_cnt >= BURST_LEN.
  - rd_ok = rd_enable && rd_fifo_cnt <= RD_FIFO_DEPTH-BURST_LEN.
  - Both ok: grant the direction not served last (round-robin bit, resets to favour write). One ok: grant it. Else stay in IDLE.
- WR_REQ: wr_burst_req=1 for exactly one cycle, wr_burst_addr stable, then go to WR_WAIT. RD_REQ behaves the same for the read side.
- Requests are single-cycle pulses issued only from IDLE. The controller is then idle, so every request is accepted.
- WR_WAIT:
  - wr_fifo_rd_en = wr_burst_data_req (combinational).
  - wr_burst_data = wr_fifo_dout (combinational), so data is valid in the same cycle as data_req.
  - Count beats. On wr_burst_finish: write pointer += BURST_LEN*ADDR_STEP, flip the round-robin bit, go to IDLE.
- RD_WAIT:
  - rd_fifo_wr_en = rd_burst_data_valid, gated by state==RD_WAIT.
  - rd_fifo_din = rd_burst_data.
  - Beats outside RD_WAIT are dropped. On rd_burst_finish: advance the read pointer, go to IDLE.
- Wrap: after FRAME_BEATS/BURST_LEN bursts the pointer returns to its base and the matching *_frame_done pulses with the finish-handling cycle.
- frame_sync:
  - In IDLE: both pointers and burst counters load base on the next edge.
  - During a burst: latch a pending flag and apply it when finish is handled. This overrides the normal increment.
  - Pulse coinciding with finish: sync wins.
- init_calib_complete low: no new request. A burst in flight is still waited out.
- Beat-count check: the beat count must equal BURST_LEN at finish. If not, still advance (verification asserts).

Decomposition:
- Package ddr_frame_pkg: state encoding, BURST_STEP = BURST_LEN*ADDR_STEP, bursts-per-frame constant.
- Sub-module ddr_frame_addr_gen, instantiated once per direction. Ports: base, advance, sync. Outputs: addr, frame_done.

Test Plan:
- Reset, calib=1, wr_fifo_cnt=64, rd_enable=0 -> one-cycle wr_burst_req with addr 0. 64 wr_fifo_rd_en pulses mirroring data_req. After finish the next burst uses addr 512.
- rd_enable=1, rd_fifo_cnt=0, wr_fifo_cnt=0 -> rd_burst_req addr 0. 64 valid beats give 64 rd_fifo_wr_en. A stray valid while in IDLE gives no push.
- Both eligible continuously -> grant order W,R,W,R. Addresses 0,0,512,512.
- FRAME_BEATS=256 -> after 4 write bursts, wr_frame_done pulses once and the 5th burst addr is 0.
- frame_sync asserted mid write burst at addr 1024 -> burst completes, next write addr is 0 (not 1536).
- calib=0 with wr_fifo_cnt=64 -> no request. Reset asserted mid-burst -> outputs 0 next cycle, next burst addr 0.

Source files
------------

// File: rtl/ddr_frame_pkg.sv
// Shared types and constant helpers for the DDR frame read/write initiator.
package ddr_frame_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT
  } state_t;

  localparam int unsigned BURST_LEN_W = 10;
  localparam int unsigned BEAT_CNT_W  = 11;

  // App-address distance covered by one burst.
  function automatic int unsigned burst_step(input int unsigned len, input int unsigned step);
    return len * step;
  endfunction

  function automatic int unsigned bursts_per_frame(input int unsigned frame_beats, input int unsigned len);
    return frame_beats / len;
  endfunction

endpackage

// File: rtl/ddr_frame_rw_ctrl_addr_gen.sv
// Frame-relative burst address pointer with wrap-around and frame resync.
module ddr_frame_addr_gen #(
  parameter int unsigned ADDR_WIDTH       = 28,
  parameter int unsigned BURST_STEP       = 512,
  parameter int unsigned BURSTS_PER_FRAME = 4050
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic                  i_advance,
  input  logic                  i_sync,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_frame_done
);

  localparam int unsigned CNT_W = (BURSTS_PER_FRAME > 1) ? $clog2(BURSTS_PER_FRAME) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BURSTS_PER_FRAME - 1);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_last;

  assign w_last = (r_cnt == LAST);

  // Sync overrides a coincident advance, including the wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_sync) begin
      r_addr <= i_base;
      r_cnt  <= '0;
    end else if (i_advance) begin
      if (w_last) begin
        r_addr <= i_base;
        r_cnt  <= '0;
      end else begin
        r_addr <= r_addr + ADDR_WIDTH'(BURST_STEP);
        r_cnt  <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_addr       = r_addr;
  assign o_frame_done = i_advance && !i_sync && !i_rst && w_last;

endmodule

// File: rtl/ddr_frame_rw_ctrl.sv
// User-side burst initiator: drains the ingress FIFO into DDR and refills the egress FIFO.
module ddr_frame_rw_ctrl
  import ddr_frame_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = 28,
  parameter int unsigned DATA_WIDTH    = 128,
  parameter int unsigned BURST_LEN     = 64,
  parameter int unsigned ADDR_STEP     = 8,
  parameter int unsigned FRAME_BEATS   = 259200,
  parameter int unsigned WR_BASE       = 0,
  parameter int unsigned RD_BASE       = 0,
  parameter int unsigned FIFO_CNT_W    = 11,
  parameter int unsigned RD_FIFO_DEPTH = 1024
) (
  input  logic                   ui_clk,
  input  logic                   ui_clk_sync_rst,
  input  logic                   init_calib_complete,
  input  logic                   frame_sync,
  input  logic                   rd_enable,
  input  logic [FIFO_CNT_W-1:0]  wr_fifo_cnt,
  input  logic [DATA_WIDTH-1:0]  wr_fifo_dout,
  output logic                   wr_fifo_rd_en,
  input  logic [FIFO_CNT_W-1:0]  rd_fifo_cnt,
  output logic                   rd_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]  rd_fifo_din,
  output logic                   wr_burst_req,
  output logic [BURST_LEN_W-1:0] wr_burst_len,
  output logic [ADDR_WIDTH-1:0]  wr_burst_addr,
  input  logic                   wr_burst_data_req,
  output logic [DATA_WIDTH-1:0]  wr_burst_data,
  input  logic                   wr_burst_finish,
  output logic                   rd_burst_req,
  output logic [BURST_LEN_W-1:0] rd_burst_len,
  output logic [ADDR_WIDTH-1:0]  rd_burst_addr,
  input  logic                   rd_burst_data_valid,
  input  logic [DATA_WIDTH-1:0]  rd_burst_data,
  input  logic                   rd_burst_finish,
  output logic                   wr_frame_done,
  output logic                   rd_frame_done
);

  localparam int unsigned STEP = burst_step(BURST_LEN, ADDR_STEP);
  localparam int unsigned BPF  = bursts_per_frame(FRAME_BEATS, BURST_LEN);
  localparam logic [FIFO_CNT_W-1:0] WR_THR    = FIFO_CNT_W'(BURST_LEN);
  localparam logic [FIFO_CNT_W-1:0] RD_THR    = FIFO_CNT_W'(RD_FIFO_DEPTH - BURST_LEN);
  localparam logic [BEAT_CNT_W-1:0] BEATS_EXP = BEAT_CNT_W'(BURST_LEN);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_rr_rd;
  logic                  r_sync_pend;
  logic [BEAT_CNT_W-1:0] r_wr_beats;
  logic [BEAT_CNT_W-1:0] r_rd_beats;
  logic [BEAT_CNT_W-1:0] w_wr_beats_fin;
  logic [BEAT_CNT_W-1:0] w_rd_beats_fin;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_wr_done;
  logic                  w_rd_done;
  logic                  w_sync;

  assign w_wr_ok   = (wr_fifo_cnt >= WR_THR);
  assign w_rd_ok   = rd_enable && (rd_fifo_cnt <= RD_THR);
  assign w_wr_done = (r_state == ST_WR_WAIT) && wr_burst_finish && !ui_clk_sync_rst;
  assign w_rd_done = (r_state == ST_RD_WAIT) && rd_burst_finish && !ui_clk_sync_rst;

  // A sync seen mid-burst is held until that burst's finish is handled.
  assign w_sync = !ui_clk_sync_rst &&
                  (((r_state == ST_IDLE) && frame_sync) ||
                   ((w_wr_done || w_rd_done) && (frame_sync || r_sync_pend)));

  assign wr_burst_len = BURST_LEN_W'(BURST_LEN);
  assign rd_burst_len = BURST_LEN_W'(BURST_LEN);

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) r_state <= ST_IDLE;
    else                 r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (init_calib_complete) begin
          if (w_wr_ok && w_rd_ok) w_state_next = r_rr_rd ? ST_RD_REQ : ST_WR_REQ;
          else if (w_wr_ok)       w_state_next = ST_WR_REQ;
          else if (w_rd_ok)       w_state_next = ST_RD_REQ;
        end
      end
      ST_WR_REQ:  w_state_next = ST_WR_WAIT;
      ST_WR_WAIT: if (wr_burst_finish) w_state_next = ST_IDLE;
      ST_RD_REQ:  w_state_next = ST_RD_WAIT;
      ST_RD_WAIT: if (rd_burst_finish) w_state_next = ST_IDLE;
      default:    w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    wr_burst_req  = 1'b0;
    rd_burst_req  = 1'b0;
    wr_fifo_rd_en = 1'b0;
    wr_burst_data = '0;
    rd_fifo_wr_en = 1'b0;
    rd_fifo_din   = '0;
    unique case (r_state)
      ST_WR_REQ: wr_burst_req = 1'b1;
      ST_RD_REQ: rd_burst_req = 1'b1;
      ST_WR_WAIT: begin
        wr_fifo_rd_en = wr_burst_data_req;
        wr_burst_data = wr_fifo_dout;
      end
      ST_RD_WAIT: begin
        rd_fifo_wr_en = rd_burst_data_valid;
        rd_fifo_din   = rd_burst_data;
      end
      default: ;
    endcase
  end

  // Beat totals include a beat arriving in the finish cycle itself.
  assign w_wr_beats_fin = r_wr_beats + BEAT_CNT_W'(wr_burst_data_req);
  assign w_rd_beats_fin = r_rd_beats + BEAT_CNT_W'(rd_burst_data_valid);

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      r_rr_rd     <= 1'b0;
      r_sync_pend <= 1'b0;
      r_wr_beats  <= '0;
      r_rd_beats  <= '0;
    end else begin
      if (w_wr_done)      r_rr_rd <= 1'b1;
      else if (w_rd_done) r_rr_rd <= 1'b0;

      if (w_wr_done || w_rd_done)                r_sync_pend <= 1'b0;
      else if (frame_sync && r_state != ST_IDLE) r_sync_pend <= 1'b1;

      if (r_state == ST_WR_REQ)                            r_wr_beats <= '0;
      else if (r_state == ST_WR_WAIT && wr_burst_data_req) r_wr_beats <= w_wr_beats_fin;

      if (r_state == ST_RD_REQ)                              r_rd_beats <= '0;
      else if (r_state == ST_RD_WAIT && rd_burst_data_valid) r_rd_beats <= w_rd_beats_fin;

      if (w_wr_done) assert (w_wr_beats_fin == BEATS_EXP);
      if (w_rd_done) assert (w_rd_beats_fin == BEATS_EXP);
    end
  end

  ddr_frame_addr_gen #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .BURST_STEP      (STEP),
    .BURSTS_PER_FRAME(BPF)
  ) u_wr_addr (
    .i_clk       (ui_clk),
    .i_rst       (ui_clk_sync_rst),
    .i_base      (ADDR_WIDTH'(WR_BASE)),
    .i_advance   (w_wr_done),
    .i_sync      (w_sync),
    .o_addr      (wr_burst_addr),
    .o_frame_done(wr_frame_done)
  );

  ddr_frame_addr_gen #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .BURST_STEP      (STEP),
    .BURSTS_PER_FRAME(BPF)
  ) u_rd_addr (
    .i_clk       (ui_clk),
    .i_rst       (ui_clk_sync_rst),
    .i_base      (ADDR_WIDTH'(RD_BASE)),
    .i_advance   (w_rd_done),
    .i_sync      (w_sync),
    .o_addr      (rd_burst_addr),
    .o_frame_done(rd_frame_done)
  );

endmodule

// File: tb/tb_ddr_frame_rw_ctrl.sv
// Directed bench for ddr_frame_rw_ctrl with a 4-burst frame and an emulated burst controller.
module tb_ddr_frame_rw_ctrl;

  logic          ui_clk;
  logic          ui_clk_sync_rst;
  logic          init_calib_complete;
  logic          frame_sync;
  logic          rd_enable;
  logic [10:0]   wr_fifo_cnt;
  logic [127:0]  wr_fifo_dout;
  logic          wr_fifo_rd_en;
  logic [10:0]   rd_fifo_cnt;
  logic          rd_fifo_wr_en;
  logic [127:0]  rd_fifo_din;
  logic          wr_burst_req;
  logic [9:0]    wr_burst_len;
  logic [27:0]   wr_burst_addr;
  logic          wr_burst_data_req;
  logic [127:0]  wr_burst_data;
  logic          wr_burst_finish;
  logic          rd_burst_req;
  logic [9:0]    rd_burst_len;
  logic [27:0]   rd_burst_addr;
  logic          rd_burst_data_valid;
  logic [127:0]  rd_burst_data;
  logic          rd_burst_finish;
  logic          wr_frame_done;
  logic          rd_frame_done;

  int n_cmp  = 0;
  int n_fail = 0;

  ddr_frame_rw_ctrl #(
    .FRAME_BEATS(256)
  ) dut (
    .ui_clk             (ui_clk),
    .ui_clk_sync_rst    (ui_clk_sync_rst),
    .init_calib_complete(init_calib_complete),
    .frame_sync         (frame_sync),
    .rd_enable          (rd_enable),
    .wr_fifo_cnt        (wr_fifo_cnt),
    .wr_fifo_dout       (wr_fifo_dout),
    .wr_fifo_rd_en      (wr_fifo_rd_en),
    .rd_fifo_cnt        (rd_fifo_cnt),
    .rd_fifo_wr_en      (rd_fifo_wr_en),
    .rd_fifo_din        (rd_fifo_din),
    .wr_burst_req       (wr_burst_req),
    .wr_burst_len       (wr_burst_len),
    .wr_burst_addr      (wr_burst_addr),
    .wr_burst_data_req  (wr_burst_data_req),
    .wr_burst_data      (wr_burst_data),
    .wr_burst_finish    (wr_burst_finish),
    .rd_burst_req       (rd_burst_req),
    .rd_burst_len       (rd_burst_len),
    .rd_burst_addr      (rd_burst_addr),
    .rd_burst_data_valid(rd_burst_data_valid),
    .rd_burst_data      (rd_burst_data),
    .rd_burst_finish    (rd_burst_finish),
    .wr_frame_done      (wr_frame_done),
    .rd_frame_done      (rd_frame_done)
  );

  initial ui_clk = 1'b0;
  always #5 ui_clk = ~ui_clk;

  task automatic tick();
    @(posedge ui_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // kind: 1 = write request, 2 = read request
  task automatic expect_req(input int kind, input logic [27:0] addr);
    int got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      settle();
      if (wr_burst_req)      got = 1;
      else if (rd_burst_req) got = 2;
    end
    check("req_kind", 64'(got), 64'(kind));
    if (kind == 1) check("wr_addr", 64'(wr_burst_addr), 64'(addr));
    else           check("rd_addr", 64'(rd_burst_addr), 64'(addr));
    tick();
    settle();
    check("req_one_cycle", 64'({wr_burst_req, rd_burst_req}), 64'(0));
  endtask

  task automatic wr_body(input bit exp_fd, input bit do_sync);
    int pops = 0;
    int bad  = 0;
    int fd   = 0;
    logic [127:0] pat;
    for (int i = 0; i < 65; i++) begin
      pat               = {4{32'hC0DE_0000 + 32'(i)}};
      wr_fifo_dout      = pat;
      wr_burst_data_req = (i != 32);
      frame_sync        = do_sync && (i == 10);
      settle();
      if (wr_fifo_rd_en) pops++;
      if (wr_fifo_rd_en !== wr_burst_data_req) bad++;
      if (wr_burst_data_req && (wr_burst_data !== pat)) bad++;
      if (wr_frame_done) fd++;
      tick();
    end
    wr_burst_data_req = 1'b0;
    frame_sync        = 1'b0;
    wr_burst_finish   = 1'b1;
    settle();
    if (wr_frame_done) fd++;
    tick();
    wr_burst_finish = 1'b0;
    check("wr_pops", 64'(pops), 64'(64));
    check("wr_beat_err", 64'(bad), 64'(0));
    check("wr_frame_done", 64'(fd), 64'(exp_fd));
  endtask

  task automatic rd_body(input bit exp_fd);
    int pushes = 0;
    int bad    = 0;
    int fd     = 0;
    logic [127:0] pat;
    for (int i = 0; i < 64; i++) begin
      pat                 = {4{32'h5EED_0000 + 32'(i)}};
      rd_burst_data       = pat;
      rd_burst_data_valid = 1'b1;
      settle();
      if (rd_fifo_wr_en) pushes++;
      if (rd_fifo_din !== pat) bad++;
      if (rd_frame_done) fd++;
      tick();
    end
    rd_burst_data_valid = 1'b0;
    rd_burst_finish     = 1'b1;
    settle();
    if (rd_frame_done) fd++;
    tick();
    rd_burst_finish = 1'b0;
    check("rd_pushes", 64'(pushes), 64'(64));
    check("rd_beat_err", 64'(bad), 64'(0));
    check("rd_frame_done", 64'(fd), 64'(exp_fd));
  endtask

  initial begin
    int nreq;
    ui_clk_sync_rst     = 1'b1;
    init_calib_complete = 1'b0;
    frame_sync          = 1'b0;
    rd_enable           = 1'b0;
    wr_fifo_cnt         = '0;
    wr_fifo_dout        = '0;
    rd_fifo_cnt         = '0;
    wr_burst_data_req   = 1'b0;
    wr_burst_finish     = 1'b0;
    rd_burst_data_valid = 1'b0;
    rd_burst_data       = '0;
    rd_burst_finish     = 1'b0;
    repeat (3) tick();
    settle();
    check("rst_wr_req", 64'(wr_burst_req), 64'(0));
    check("rst_rd_req", 64'(rd_burst_req), 64'(0));
    check("rst_wr_addr", 64'(wr_burst_addr), 64'(0));
    check("rst_rd_addr", 64'(rd_burst_addr), 64'(0));
    check("rst_wr_len", 64'(wr_burst_len), 64'(64));
    check("rst_rd_len", 64'(rd_burst_len), 64'(64));
    check("rst_pops", 64'({wr_fifo_rd_en, rd_fifo_wr_en}), 64'(0));
    check("rst_fdone", 64'({wr_frame_done, rd_frame_done}), 64'(0));

    // Write-only traffic: two consecutive bursts
    ui_clk_sync_rst     = 1'b0;
    init_calib_complete = 1'b1;
    wr_fifo_cnt         = 11'd64;
    expect_req(1, 28'd0);
    wr_body(1'b0, 1'b0);
    expect_req(1, 28'd512);
    wr_fifo_cnt = '0;
    wr_body(1'b0, 1'b0);

    // Read-only traffic, then stray beats while idle
    rd_enable = 1'b1;
    expect_req(2, 28'd0);
    rd_enable = 1'b0;
    rd_body(1'b0);
    rd_burst_data_valid = 1'b1;
    wr_burst_data_req   = 1'b1;
    settle();
    check("idle_rd_push", 64'(rd_fifo_wr_en), 64'(0));
    check("idle_wr_pop", 64'(wr_fifo_rd_en), 64'(0));
    tick();
    rd_burst_data_valid = 1'b0;
    wr_burst_data_req   = 1'b0;

    // frame_sync in IDLE, then both directions eligible: W,R,W,R
    frame_sync = 1'b1;
    tick();
    frame_sync  = 1'b0;
    wr_fifo_cnt = 11'd64;
    rd_enable   = 1'b1;
    rd_fifo_cnt = 11'd960;
    expect_req(1, 28'd0);
    wr_body(1'b0, 1'b0);
    expect_req(2, 28'd0);
    rd_body(1'b0);
    expect_req(1, 28'd512);
    wr_body(1'b0, 1'b0);
    expect_req(2, 28'd512);
    wr_fifo_cnt = '0;
    rd_enable   = 1'b0;
    rd_body(1'b0);

    // Frame wrap after 4 write bursts, then mid-burst frame_sync
    wr_fifo_cnt = 11'd64;
    expect_req(1, 28'd1024);
    wr_body(1'b0, 1'b0);
    expect_req(1, 28'd1536);
    wr_body(1'b1, 1'b0);
    expect_req(1, 28'd0);
    wr_body(1'b0, 1'b0);
    expect_req(1, 28'd512);
    wr_body(1'b0, 1'b0);
    expect_req(1, 28'd1024);
    wr_body(1'b0, 1'b1);
    expect_req(1, 28'd0);
    wr_fifo_cnt = '0;
    wr_body(1'b0, 1'b0);

    // Calibration low blocks new requests
    init_calib_complete = 1'b0;
    wr_fifo_cnt         = 11'd64;
    nreq                = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      settle();
      if (wr_burst_req || rd_burst_req) nreq++;
    end
    check("nocalib_reqs", 64'(nreq), 64'(0));

    // Reset in the middle of a write burst
    init_calib_complete = 1'b1;
    expect_req(1, 28'd512);
    wr_burst_data_req = 1'b1;
    repeat (5) tick();
    ui_clk_sync_rst = 1'b1;
    tick();
    settle();
    check("midrst_pop", 64'(wr_fifo_rd_en), 64'(0));
    check("midrst_data", 64'(wr_burst_data[63:0]), 64'(0));
    check("midrst_req", 64'(wr_burst_req), 64'(0));
    check("midrst_addr", 64'(wr_burst_addr), 64'(0));
    ui_clk_sync_rst   = 1'b0;
    wr_burst_data_req = 1'b0;
    expect_req(1, 28'd0);
    wr_fifo_cnt = '0;
    wr_body(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
